// File: rtl/hack_io_pkg.sv
// Shared constants and types for the Hack memory-mapped I/O ports.
package hack_io_pkg;

    localparam logic [14:0] TX_ADDR_DEF   = 15'h6001;
    localparam logic [14:0] STAT_ADDR_DEF = 15'h6002;

    localparam int unsigned ST_FULL    = 0;
    localparam int unsigned ST_EMPTY   = 1;
    localparam int unsigned ST_OVF     = 2;
    localparam int unsigned ST_BUSY    = 3;
    localparam int unsigned ST_CNT_LSB = 4;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;

    function automatic logic [3:0] sat_count4(input int unsigned c);
        return (c > 15) ? 4'hF : 4'(c);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with wrap-bit pointers; pushes when full and
// pops when empty are ignored.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/hack_uart_tx_port.sv
// Memory-mapped 8N1 UART transmit port for the Hack CPU data bus: a TX data
// register feeding a FIFO, and a status register with a sticky overflow flag.
module hack_uart_tx_port
    import hack_io_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter logic [14:0] TX_ADDR      = TX_ADDR_DEF,
    parameter logic [14:0] STAT_ADDR    = STAT_ADDR_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [14:0] addressM,
    input  logic [15:0] outM,
    input  logic        writeM,
    output logic [15:0] rd_data,
    output logic        txd,
    output logic        tx_busy
);

    localparam int unsigned BW = $clog2(CLKS_PER_BIT);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

    uart_tx_state_t state_q;
    logic [BW-1:0]  baud_q;
    logic [2:0]     bit_idx_q;
    logic [7:0]     shift_q;
    logic           txd_q, busy_q;
    logic           overflow_q, overflow_d;

    logic           wr_tx, wr_stat;
    logic           fifo_pop, fifo_full, fifo_empty;
    logic [7:0]     fifo_dout;
    logic [CW-1:0]  fifo_count;
    logic           baud_done;
    logic [15:0]    status_word;
    logic           unused_outm_hi;

    assign wr_tx          = writeM && (addressM == TX_ADDR);
    assign wr_stat        = writeM && (addressM == STAT_ADDR);
    assign fifo_pop       = (state_q == IDLE) && !fifo_empty;
    assign baud_done      = (baud_q == BAUD_MAX);
    assign unused_outm_hi = ^outM[15:8];

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .push_i  (wr_tx),
        .pop_i   (fifo_pop),
        .data_i  (outM[7:0]),
        .data_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Full is sampled before any same-cycle pop, so a store into a full FIFO always drops.
    always_comb begin
        overflow_d = overflow_q;
        if (wr_stat && outM[ST_OVF]) overflow_d = 1'b0;
        if (wr_tx && fifo_full)      overflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) overflow_q <= 1'b0;
        else          overflow_q <= overflow_d;
    end

    always_comb begin
        status_word                      = '0;
        status_word[ST_FULL]             = fifo_full;
        status_word[ST_EMPTY]            = fifo_empty;
        status_word[ST_OVF]              = overflow_q;
        status_word[ST_BUSY]             = busy_q;
        status_word[ST_CNT_LSB +: 4]     = sat_count4(32'(fifo_count));
        rd_data = (addressM == STAT_ADDR) ? status_word : '0;
    end

    // txd/busy are registered from the current state, so the line trails the
    // state by one clock: pop at edge N+1 puts the start bit out at edge N+2.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            busy_q <= (state_q != IDLE);
            unique case (state_q)
                IDLE: begin
                    txd_q <= 1'b1;
                    if (!fifo_empty) begin
                        shift_q   <= fifo_dout;
                        baud_q    <= '0;
                        bit_idx_q <= '0;
                        state_q   <= START;
                    end
                end
                START: begin
                    txd_q <= 1'b0;
                    if (baud_done) begin
                        baud_q  <= '0;
                        state_q <= DATA;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                DATA: begin
                    txd_q <= shift_q[bit_idx_q];
                    if (baud_done) begin
                        baud_q <= '0;
                        if (bit_idx_q == 3'd7) state_q   <= STOP;
                        else                   bit_idx_q <= bit_idx_q + 1'b1;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                STOP: begin
                    txd_q <= 1'b1;
                    if (baud_done) begin
                        baud_q  <= '0;
                        state_q <= IDLE;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign txd     = txd_q;
    assign tx_busy = busy_q;

endmodule

// File: tb/tb_hack_uart_tx_port.sv
// Directed bench for hack_uart_tx_port with CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_hack_uart_tx_port;

    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [14:0] addressM = 15'h6002;
    logic [15:0] outM = '0;
    logic        writeM = 1'b0;
    logic [15:0] rd_data;
    logic        txd, tx_busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        we;
        logic [14:0] wa;
        logic [15:0] wd;
        logic [14:0] ra;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[8];

    always #5 clk = ~clk;

    hack_uart_tx_port #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .TX_ADDR      (15'h6001),
        .STAT_ADDR    (15'h6002)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .addressM (addressM),
        .outM     (outM),
        .writeM   (writeM),
        .rd_data  (rd_data),
        .txd      (txd),
        .tx_busy  (tx_busy)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic store(input logic [14:0] a, input logic [15:0] d);
        addressM = a;
        outM     = d;
        writeM   = 1'b1;
        cyc();
        writeM   = 1'b0;
        outM     = '0;
        addressM = 15'h6002;
        #1;
    endtask

    // Checks one full frame; entered just after the edge where the start bit appears.
    task automatic frame(input logic [7:0] b, input string nm);
        logic exp_bit;
        for (int k = 0; k < 10 * CPB; k++) begin
            if (k / CPB == 0)      exp_bit = 1'b0;
            else if (k / CPB == 9) exp_bit = 1'b1;
            else                   exp_bit = b[k / CPB - 1];
            chk($sformatf("%s_clk%0d_txd_busy", nm, k), {14'd0, txd, tx_busy}, {14'd0, exp_bit, 1'b1});
            cyc();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;

        tbl[0] = '{1'b1, 15'h6000, 16'h00A5, 15'h6002, 16'h0002};
        tbl[1] = '{1'b1, 15'h0000, 16'h00FF, 15'h6002, 16'h0002};
        tbl[2] = '{1'b0, 15'h6002, 16'h0000, 15'h6001, 16'h0000};
        tbl[3] = '{1'b0, 15'h6002, 16'h0000, 15'h0000, 16'h0000};
        tbl[4] = '{1'b0, 15'h6002, 16'h0000, 15'h7FFF, 16'h0000};
        tbl[5] = '{1'b1, 15'h6002, 16'hFFFB, 15'h6002, 16'h0002};
        tbl[6] = '{1'b1, 15'h6003, 16'h0011, 15'h6003, 16'h0000};
        tbl[7] = '{1'b0, 15'h6001, 16'h0033, 15'h6002, 16'h0002};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_txd_busy", {14'd0, txd, tx_busy}, 16'h0002);
        chk("reset_status", rd_data, 16'h0002);
        reset_n = 1'b1;
        cyc();

        // Single byte: push at edge N, start bit at edge N+2
        store(15'h6001, 16'h00A5);
        chk("single_status_after_push", rd_data, 16'h0010);
        cyc();
        chk("single_n1_txd_busy", {14'd0, txd, tx_busy}, 16'h0002);
        chk("single_n1_status", rd_data, 16'h0002);
        cyc();
        frame(8'hA5, "single");
        chk("single_end_txd_busy", {14'd0, txd, tx_busy}, 16'h0002);
        chk("single_end_status", rd_data, 16'h0002);

        // Address decode table
        foreach (tbl[i]) begin
            addressM = tbl[i].wa;
            outM     = tbl[i].wd;
            writeM   = tbl[i].we;
            cyc();
            writeM   = 1'b0;
            outM     = '0;
            addressM = tbl[i].ra;
            #1;
            chk($sformatf("decode%0d", i), rd_data, tbl[i].exp);
        end
        addressM = 15'h6002;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            cyc();
            if (txd !== 1'b1 || tx_busy !== 1'b0) bad++;
        end
        chk("decode_no_frame", 16'(bad), 16'h0000);
        chk("decode_status", rd_data, 16'h0002);

        // Back-to-back: three frames with exactly one idle clock between them
        addressM = 15'h6001;
        writeM   = 1'b1;
        outM     = 16'h0001; cyc();
        outM     = 16'h0002; cyc();
        outM     = 16'h0003; cyc();
        writeM   = 1'b0;
        outM     = '0;
        addressM = 15'h6002;
        #1;
        for (int f = 0; f < 3; f++) begin
            chk($sformatf("b2b_count_f%0d", f), {12'd0, rd_data[7:4]}, 16'(2 - f));
            frame(8'(f + 1), $sformatf("b2b_f%0d", f));
            chk($sformatf("b2b_gap_f%0d", f), {14'd0, txd, tx_busy}, 16'h0002);
            cyc();
        end
        chk("b2b_end_txd_busy", {14'd0, txd, tx_busy}, 16'h0002);
        chk("b2b_end_status", rd_data, 16'h0002);

        // Overflow: six stores, one popped, four queued, sixth dropped
        addressM = 15'h6001;
        writeM   = 1'b1;
        for (int i = 0; i < 6; i++) begin
            outM = 16'h0010 + 16'(i);
            cyc();
        end
        writeM   = 1'b0;
        outM     = '0;
        addressM = 15'h6002;
        #1;
        chk("ovf_status", rd_data, 16'h004D);
        store(15'h6002, 16'h00FB);
        chk("ovf_clear_without_bit2", rd_data, 16'h004D);
        store(15'h6002, 16'h0004);
        chk("ovf_cleared", rd_data, 16'h0049);
        store(15'h6001, 16'h0077);
        chk("ovf_reset_again", rd_data, 16'h004D);
        store(15'h6002, 16'hFFFF);
        chk("ovf_cleared_again", rd_data, 16'h0049);

        // Reset during DATA bit 3 of byte 0x10 (start edge N+2, bit 3 at N+18..N+21)
        repeat (10) cyc();
        chk("mid_pre_reset_txd_busy", {14'd0, txd, tx_busy}, 16'h0001);
        reset_n = 1'b0;
        #1;
        chk("mid_reset_txd_busy", {14'd0, txd, tx_busy}, 16'h0002);
        chk("mid_reset_status", rd_data, 16'h0002);
        cyc();
        cyc();
        reset_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            cyc();
            if (txd !== 1'b1 || tx_busy !== 1'b0) bad++;
        end
        chk("mid_no_more_frames", 16'(bad), 16'h0000);
        chk("mid_post_status", rd_data, 16'h0002);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
